// File: rtl/hazard_pkg.sv
// Shared encodings for the ID-stage hazard controller: opcodes, forwarding
// selects, stage-register bit positions and flush FSM states.
package hazard_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_CSR    = 7'b1110011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [1:0] {
        FW_RF  = 2'b00,
        FW_EX  = 2'b01,
        FW_MEM = 2'b10,
        FW_WB  = 2'b11
    } fw_sel_e;

    localparam int unsigned STG_IFID  = 3;
    localparam int unsigned STG_IDEX  = 2;
    localparam int unsigned STG_EXMEM = 1;
    localparam int unsigned STG_MEMWB = 0;

    localparam logic [3:0] MASK_IFID  = 4'b1 << STG_IFID;
    localparam logic [3:0] MASK_IDEX  = 4'b1 << STG_IDEX;
    localparam logic [3:0] MASK_EXMEM = 4'b1 << STG_EXMEM;
    localparam logic [3:0] MASK_MEMWB = 4'b1 << STG_MEMWB;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } flush_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// One busy bit per architectural register for long-latency results, with
// per-source lookup and a bypass for the cycle the result is written back.
module hazard_scoreboard #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   issue_i,
    input  logic [4:0]             issue_rd_i,
    input  logic                   done_i,
    input  logic [4:0]             done_rd_i,
    input  logic [5*NUM_SRC-1:0]   rs_i,
    input  logic [NUM_SRC-1:0]     rs_vld_i,
    output logic [NUM_SRC-1:0]     hit_o,
    output logic [NUM_SRC-1:0]     bypass_o,
    output logic                   waw_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [4:0]          rs;

    // Set is applied after clear so a same-cycle reissue leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (done_i)
            busy_d[done_rd_i] = 1'b0;
        if (issue_i && issue_rd_i != '0)
            busy_d[issue_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    always_comb begin
        hit_o    = '0;
        bypass_o = '0;
        rs       = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            rs = rs_i[5*k +: 5];
            if (rs_vld_i[k] && rs != '0 && busy_q[rs]) begin
                if (done_i && done_rd_i == rs)
                    bypass_o[k] = 1'b1;
                else
                    hit_o[k] = 1'b1;
            end
        end
        waw_o = issue_i & busy_q[issue_rd_i];
    end

endmodule

// File: rtl/hazard_unit_sb.sv
// ID-stage hazard controller: forwarding selects, load/CSR and scoreboard
// stalls, multi-cycle trap/mret flush and a saturating stall counter.
module hazard_unit_sb
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [5*NUM_SRC-1:0]   rs_id_i,
    input  logic [NUM_SRC-1:0]     rs_vld_i,
    input  logic [4:0]             rd_ex_i,
    input  logic [4:0]             rd_mem_i,
    input  logic [4:0]             rd_wb_i,
    input  logic                   wr_ex_i,
    input  logic                   wr_mem_i,
    input  logic                   wr_wb_i,
    input  logic                   ex_is_load_i,
    input  logic                   ex_is_csr_i,
    input  logic                   mem_is_csr_i,
    input  logic                   id_is_jump_i,
    input  logic                   id_br_taken_i,
    input  logic                   mem_busy_i,
    input  logic                   if_busy_i,
    input  logic                   trap_i,
    input  logic                   mret_i,
    input  logic                   lat_issue_i,
    input  logic [4:0]             lat_rd_i,
    input  logic                   lat_done_i,
    input  logic [4:0]             lat_done_rd_i,
    output logic [2*NUM_SRC-1:0]   fw_sel_o,
    output logic [3:0]             en_o,
    output logic [3:0]             clear_o,
    output logic                   pc_en_o,
    output logic                   stall_o,
    output logic                   flush_busy_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    flush_state_e        state_q, state_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [NUM_SRC-1:0]  sb_hit, sb_bypass;
    logic                sb_waw, lu_hit, trap_any;
    logic [4:0]          rs;
    fw_sel_e             sel;

    assign trap_any = trap_i | mret_i;

    hazard_scoreboard #(
        .NUM_SRC  (NUM_SRC),
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .issue_i    (lat_issue_i),
        .issue_rd_i (lat_rd_i),
        .done_i     (lat_done_i),
        .done_rd_i  (lat_done_rd_i),
        .rs_i       (rs_id_i),
        .rs_vld_i   (rs_vld_i),
        .hit_o      (sb_hit),
        .bypass_o   (sb_bypass),
        .waw_o      (sb_waw)
    );

    // A completing long-latency result is taken from the WB path.
    always_comb begin
        fw_sel_o = '0;
        lu_hit   = 1'b0;
        rs       = '0;
        sel      = FW_RF;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            rs  = rs_id_i[5*k +: 5];
            sel = FW_RF;
            if (rs_vld_i[k] && rs != '0) begin
                if (wr_ex_i && rd_ex_i == rs)
                    sel = FW_EX;
                else if (wr_mem_i && rd_mem_i == rs)
                    sel = FW_MEM;
                else if ((wr_wb_i && rd_wb_i == rs) || sb_bypass[k])
                    sel = FW_WB;
                if (((ex_is_load_i || ex_is_csr_i) && rd_ex_i == rs) ||
                    (mem_is_csr_i && rd_mem_i == rs))
                    lu_hit = 1'b1;
            end
            if (!rst_i)
                fw_sel_o[2*k +: 2] = sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (trap_any && FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FC_RELOAD;
                end
            end
            ST_FLUSH: begin
                if (trap_any) begin
                    fcnt_d = FC_RELOAD;
                end else if (fcnt_q <= FC_W'(1)) begin
                    state_d = ST_IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        en_o         = '1;
        clear_o      = '0;
        pc_en_o      = 1'b1;
        stall_o      = 1'b0;
        flush_busy_o = (state_q == ST_FLUSH);
        if (rst_i) begin
            en_o    = '0;
            clear_o = '1;
            pc_en_o = 1'b0;
        end else if (state_q == ST_FLUSH) begin
            clear_o = trap_any ? 4'b1111 : MASK_IFID;
        end else if (trap_any) begin
            clear_o = '1;
        end else if (mem_busy_i) begin
            en_o    = MASK_MEMWB;
            clear_o = MASK_MEMWB;
            pc_en_o = 1'b0;
        end else if (lu_hit || (|sb_hit) || sb_waw) begin
            en_o    = MASK_IDEX | MASK_EXMEM | MASK_MEMWB;
            clear_o = MASK_IDEX;
            pc_en_o = 1'b0;
            stall_o = 1'b1;
        end else if (id_is_jump_i || id_br_taken_i) begin
            clear_o = MASK_IFID;
        end else if (if_busy_i) begin
            clear_o = MASK_IFID;
            pc_en_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cnt_q <= '0;
        else if (stall_o && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Randomised and directed bench for hazard_unit_sb against a cycle-level
// reference model built from the priority rules.
module tb_hazard_unit_sb;

    localparam int unsigned NS      = 2;
    localparam int unsigned FC      = 3;
    localparam int unsigned CW      = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [5*NS-1:0] rs_id;
    logic [NS-1:0]   rs_vld;
    logic [4:0]      rd_ex, rd_mem, rd_wb, lat_rd, lat_done_rd;
    logic            wr_ex, wr_mem, wr_wb, ex_load, ex_csr, mem_csr;
    logic            jump, br_taken, mem_busy, if_busy, trap, mret;
    logic            lat_issue, lat_done;
    logic [2*NS-1:0] fw_sel;
    logic [3:0]      en, clear;
    logic            pc_en, stall, flush_busy;
    logic [CW-1:0]   stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    int unsigned flush_left;
    bit          sb[32];
    int unsigned scnt;

    logic [2*NS-1:0] e_fw;
    logic [3:0]      e_en, e_clear;
    logic            e_pc, e_stall, e_busy;
    logic [CW-1:0]   e_cnt;

    hazard_unit_sb #(
        .NUM_SRC      (NS),
        .NUM_REGS     (32),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rs_id_i       (rs_id),
        .rs_vld_i      (rs_vld),
        .rd_ex_i       (rd_ex),
        .rd_mem_i      (rd_mem),
        .rd_wb_i       (rd_wb),
        .wr_ex_i       (wr_ex),
        .wr_mem_i      (wr_mem),
        .wr_wb_i       (wr_wb),
        .ex_is_load_i  (ex_load),
        .ex_is_csr_i   (ex_csr),
        .mem_is_csr_i  (mem_csr),
        .id_is_jump_i  (jump),
        .id_br_taken_i (br_taken),
        .mem_busy_i    (mem_busy),
        .if_busy_i     (if_busy),
        .trap_i        (trap),
        .mret_i        (mret),
        .lat_issue_i   (lat_issue),
        .lat_rd_i      (lat_rd),
        .lat_done_i    (lat_done),
        .lat_done_rd_i (lat_done_rd),
        .fw_sel_o      (fw_sel),
        .en_o          (en),
        .clear_o       (clear),
        .pc_en_o       (pc_en),
        .stall_o       (stall),
        .flush_busy_o  (flush_busy),
        .stall_cnt_o   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic quiet();
        rst = 0; rs_id = '0; rs_vld = '0;
        rd_ex = '0; rd_mem = '0; rd_wb = '0; lat_rd = '0; lat_done_rd = '0;
        wr_ex = 0; wr_mem = 0; wr_wb = 0; ex_load = 0; ex_csr = 0; mem_csr = 0;
        jump = 0; br_taken = 0; mem_busy = 0; if_busy = 0; trap = 0; mret = 0;
        lat_issue = 0; lat_done = 0;
    endtask

    task automatic model_eval();
        logic [4:0] r;
        bit hz = 0;
        e_fw = '0;
        for (int k = 0; k < NS; k++) begin
            r = rs_id[5*k +: 5];
            if (rs_vld[k] && r != 5'd0) begin
                if (wr_ex && rd_ex == r)        e_fw[2*k +: 2] = 2'd1;
                else if (wr_mem && rd_mem == r) e_fw[2*k +: 2] = 2'd2;
                else if ((wr_wb && rd_wb == r) || (sb[r] && lat_done && lat_done_rd == r))
                    e_fw[2*k +: 2] = 2'd3;
                if (((ex_load || ex_csr) && rd_ex == r) || (mem_csr && rd_mem == r)) hz = 1;
                if (sb[r] && !(lat_done && lat_done_rd == r)) hz = 1;
            end
        end
        if (lat_issue && sb[lat_rd]) hz = 1;
        e_stall = 0;
        e_busy  = !rst && flush_left > 0;
        e_cnt   = rst ? '0 : CW'(scnt);
        if (rst) begin
            e_fw = '0; e_en = 4'h0; e_clear = 4'hF; e_pc = 0;
        end else if (flush_left > 0) begin
            e_en = 4'hF; e_clear = (trap || mret) ? 4'hF : 4'h8; e_pc = 1;
        end else if (trap || mret) begin
            e_en = 4'hF; e_clear = 4'hF; e_pc = 1;
        end else if (mem_busy) begin
            e_en = 4'h1; e_clear = 4'h1; e_pc = 0;
        end else if (hz) begin
            e_en = 4'h7; e_clear = 4'h4; e_pc = 0; e_stall = 1;
        end else if (jump || br_taken) begin
            e_en = 4'hF; e_clear = 4'h8; e_pc = 1;
        end else if (if_busy) begin
            e_en = 4'hF; e_clear = 4'h8; e_pc = 0;
        end else begin
            e_en = 4'hF; e_clear = 4'h0; e_pc = 1;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            flush_left = 0; scnt = 0;
            foreach (sb[i]) sb[i] = 0;
            return;
        end
        if (flush_left > 0)
            flush_left = (trap || mret) ? FC - 1 : flush_left - 1;
        else if (trap || mret)
            flush_left = FC - 1;
        if (e_stall && scnt < CNT_MAX) scnt++;
        if (lat_done) sb[lat_done_rd] = 0;
        if (lat_issue && lat_rd != 5'd0) sb[lat_rd] = 1;
    endtask

    // Inputs are applied in the low phase; outputs checked 2ns later,
    // the model advances on the following rising edge.
    task automatic step();
        #2;
        model_eval();
        check("fw",    32'(fw_sel),     32'(e_fw));
        check("en",    32'(en),         32'(e_en));
        check("clear", 32'(clear),      32'(e_clear));
        check("pc_en", 32'(pc_en),      32'(e_pc));
        check("stall", 32'(stall),      32'(e_stall));
        check("busy",  32'(flush_busy), 32'(e_busy));
        check("cnt",   32'(stall_cnt),  32'(e_cnt));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 4));
    endfunction

    initial begin
        quiet();
        rst = 1;
        flush_left = 0; scnt = 0;
        foreach (sb[i]) sb[i] = 0;
        #2;
        check("rst_en",    32'(en),    32'h0);
        check("rst_clear", 32'(clear), 32'hF);
        step();
        quiet(); step();

        // forwarding priority EX over MEM, then x0 never forwards
        wr_ex = 1; rd_ex = 5; wr_mem = 1; rd_mem = 5; rs_vld = 2'b01; rs_id[4:0] = 5;
        #1 check("t1_fw_ex", 32'(fw_sel[1:0]), 32'h1);
        step();
        rs_id[4:0] = 0; rd_ex = 0; rd_mem = 0; step();

        // load-use stall on src1
        quiet(); ex_load = 1; rd_ex = 7; rs_vld = 2'b10; rs_id[9:5] = 7;
        #1 check("t2_en", 32'(en), 32'h7);
        step(); step();

        // scoreboard: issue, stall while busy, bypass on done
        quiet(); lat_issue = 1; lat_rd = 9; step();
        quiet(); rs_vld = 2'b01; rs_id[4:0] = 9;
        for (int i = 0; i < 3; i++) step();
        lat_done = 1; lat_done_rd = 9;
        #1 check("t3_fw_wb", 32'(fw_sel[1:0]), 32'h3);
        check("t3_nostall", 32'(stall), 32'h0);
        step();

        // same-cycle issue and done keep the bit set
        quiet(); lat_issue = 1; lat_rd = 9; step();
        lat_done = 1; lat_done_rd = 9; step();
        quiet(); rs_vld = 2'b01; rs_id[4:0] = 9;
        #1 check("t4_stall", 32'(stall), 32'h1);
        step();

        // trap beats mem_busy, flush runs, trap mid-flush reloads
        quiet(); trap = 1; mem_busy = 1;
        #1 check("t5_clear", 32'(clear), 32'hF);
        step();
        quiet(); step();
        mret = 1; step();
        quiet();
        for (int i = 0; i < 3; i++) step();

        // async reset mid-stall with scoreboard busy
        rs_vld = 2'b01; rs_id[4:0] = 9; step();
        rst = 1;
        #1 check("t6_en", 32'(en), 32'h0);
        step();
        rst = 0; step();

        // stall counter saturation
        quiet(); ex_csr = 1; rd_ex = 3; rs_vld = 2'b11; rs_id[9:5] = 3;
        for (int i = 0; i < 20; i++) step();
        check("t6_sat", 32'(stall_cnt), CNT_MAX);

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            rs_id     = {rnd_reg(), rnd_reg()};
            rs_vld    = NS'($urandom);
            rd_ex     = rnd_reg(); rd_mem = rnd_reg(); rd_wb = rnd_reg();
            wr_ex     = 1'($urandom); wr_mem = 1'($urandom); wr_wb = 1'($urandom);
            ex_load   = ($urandom_range(0, 3) == 0);
            ex_csr    = ($urandom_range(0, 9) == 0);
            mem_csr   = ($urandom_range(0, 9) == 0);
            jump      = ($urandom_range(0, 7) == 0);
            br_taken  = ($urandom_range(0, 7) == 0);
            mem_busy  = ($urandom_range(0, 9) == 0);
            if_busy   = ($urandom_range(0, 5) == 0);
            trap      = ($urandom_range(0, 24) == 0);
            mret      = ($urandom_range(0, 39) == 0);
            lat_issue = ($urandom_range(0, 4) == 0);
            lat_rd    = rnd_reg();
            lat_done  = ($urandom_range(0, 3) == 0);
            lat_done_rd = rnd_reg();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
